// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and loader ports.
// With MEM_ARB_RR_EN defined a preference pointer alternates the winner
// under contention; otherwise the CPU port has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Contention goes to the pointed-at port; a lone requester always wins.
  always_comb begin
    grant_id = PORT_CPU;
    if (req0 && req1) grant_id = ptr_q;
    else if (req1)    grant_id = PORT_LDR;
    ptr_d = take ? ~grant_id : ptr_q;
  end

  // Pointer moves to the losing port whenever a grant is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PORT_CPU;
    else        ptr_q <= ptr_d;
  end
`else
  // CPU wins whenever it asks; loader only when the CPU is quiet.
  always_comb begin
    grant_id = (!req0 && req1) ? PORT_LDR : PORT_CPU;
  end

  logic unused_pick;
  assign unused_pick = ^{clk, rst_n, take};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port system memory.
// IDLE/DONE arbitrate and latch the winner's request, ACC drives the
// memory for one cycle, DONE pulses the winner's ack.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              acc_id_q, acc_id_d;
  logic              acc_we_q, acc_we_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic grant_valid, grant_id, take;

  mem_arb_pick u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .take       (take),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Next state: arbitrate out of IDLE/DONE, complete the access out of ACC.
  // The access registers double as mem_addr/mem_din so they hold between
  // accesses; mem_we/busy/ack are registered so no req->ack comb path exists.
  always_comb begin
    state_d     = state_q;
    acc_id_d    = acc_id_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    take        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (grant_valid) begin
          take        = 1'b1;
          state_d     = ACC;
          acc_id_d    = grant_id;
          acc_we_d    = (grant_id == PORT_LDR) ? we1    : we0;
          acc_addr_d  = (grant_id == PORT_LDR) ? addr1  : addr0;
          acc_wdata_d = (grant_id == PORT_LDR) ? wdata1 : wdata0;
          mem_we_d    = (grant_id == PORT_LDR) ? we1    : we0;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        state_d = DONE;
        if (acc_id_q == PORT_LDR) begin
          ack1_d = 1'b1;
          if (!acc_we_q) rdata1_d = mem_dout;
        end else begin
          ack0_d = 1'b1;
          if (!acc_we_q) rdata0_d = mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_id_q    <= PORT_CPU;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_id_q    <= acc_id_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign mem_addr = acc_addr_q;
  assign mem_din  = acc_wdata_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_we, busy;
  logic [7:0]  rdata0, rdata1, mem_din, mem_dout;
  logic [15:0] mem_addr;

  logic [7:0]  mem [0:65535];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Synchronous-write, combinational-read memory model.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  task automatic issue(input bit p, input logic we, input logic [15:0] a, input logic [7:0] d);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Waits at negedges for the port's ack, bounded to 20 cycles.
  task automatic wait_ack(input bit p, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(p ? ack1 : ack0) && lat < 20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({ack0, ack1, mem_we, busy, rdata0, rdata1, mem_addr, mem_din} !== '0) begin
      fails++;
      $display("FAIL reset_values: ack0=%b ack1=%b we=%b busy=%b rd0=%h rd1=%h addr=%h din=%h, all required 0",
               ack0, ack1, mem_we, busy, rdata0, rdata1, mem_addr, mem_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat;
    issue(1'b1, 1'b0, 16'h0200, 8'h00);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0200) begin
      fails++;
      $display("FAIL read_acc_drive: busy=%b we=%b addr=%h, required 1 0 0200", busy, mem_we, mem_addr);
    end
    wait_ack(1'b1, lat);
    lat++;
    tests++;
    if (lat !== 2 || ack0 !== 1'b0) begin
      fails++;
      $display("FAIL read_latency: got %0d cycles ack0=%b, required 2 cycles ack0=0", lat, ack0);
    end
    tests++;
    if (rdata1 !== 8'hB9) begin
      fails++;
      $display("FAIL read_rdata1: got %h, required b9", rdata1);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b0, 1'b1, 16'h0010, 8'h5A);
    wait_ack(1'b0, lat);
    req0 = 1'b0;
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL write_latency: got %0d cycles, required 2", lat);
    end
    tests++;
    if (rdata0 !== 8'h00) begin
      fails++;
      $display("FAIL write_keeps_rdata0: got %h, required 00", rdata0);
    end
    @(negedge clk);
    tests++;
    if (mem[16'h0010] !== 8'h5A) begin
      fails++;
      $display("FAIL write_mem: mem[0010]=%h, required 5a", mem[16'h0010]);
    end
    issue(1'b0, 1'b0, 16'h0010, 8'h00);
    wait_ack(1'b0, lat);
    req0 = 1'b0;
    tests++;
    if (rdata0 !== 8'h5A || lat !== 2) begin
      fails++;
      $display("FAIL readback: rdata0=%h lat=%0d, required 5a lat 2", rdata0, lat);
    end
    tests++;
    if (rdata1 !== 8'hB9) begin
      fails++;
      $display("FAIL rdata1_hold: got %h, required b9", rdata1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(1'b0, 1'b0, 16'h0000, 8'h00);
    wait_ack(1'b0, lat);
    tests++;
    if (rdata0 !== 8'h11) begin
      fails++;
      $display("FAIL b2b_first: rdata0=%h, required 11", rdata0);
    end
    addr0 = 16'h0001;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || mem_addr !== 16'h0001 || ack0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_gap: busy=%b addr=%h ack0=%b, required 1 0001 0", busy, mem_addr, ack0);
    end
    @(negedge clk);
    tests++;
    if (ack0 !== 1'b1 || rdata0 !== 8'h33) begin
      fails++;
      $display("FAIL b2b_second: ack0=%b rdata0=%h, required 1 33", ack0, rdata0);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    issue(1'b0, 1'b0, 16'h0020, 8'h00);
    @(negedge clk);
    addr0 = 16'h0021;
    #1;
    tests++;
    if (mem_addr !== 16'h0020) begin
      fails++;
      $display("FAIL latch_addr: mem_addr=%h, required 0020", mem_addr);
    end
    @(negedge clk);
    tests++;
    if (ack0 !== 1'b1 || rdata0 !== 8'h77) begin
      fails++;
      $display("FAIL latch_rdata: ack0=%b rdata0=%h, required 1 77", ack0, rdata0);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] exp_c [8];
`ifdef MEM_ARB_RR_EN
    exp_c = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
    exp_c = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif
    do_reset();
    issue(1'b0, 1'b0, 16'h0000, 8'h00);
    issue(1'b1, 1'b0, 16'h0200, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if ({ack1, ack0} !== exp_c[i]) begin
        fails++;
        $display("FAIL contention_c%0d: {ack1,ack0}=%b, required %b", i, {ack1, ack0}, exp_c[i]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    issue(1'b0, 1'b1, 16'h0006, 8'hFF);
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstw_acc: mem_we=%b busy=%b, required 1 1", mem_we, busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ack0, ack1, mem_we, busy, rdata0, rdata1, mem_addr, mem_din} !== '0) begin
      fails++;
      $display("FAIL rstw_async: ack0=%b ack1=%b we=%b busy=%b rd0=%h rd1=%h addr=%h din=%h, all required 0",
               ack0, ack1, mem_we, busy, rdata0, rdata1, mem_addr, mem_din);
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (mem[16'h0006] !== 8'h42) begin
      fails++;
      $display("FAIL rstw_mem: mem[0006]=%h, required 42", mem[16'h0006]);
    end
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ack0 || ack1 || busy) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
        fails++;
        $display("FAIL rstw_no_ack: activity seen after aborted access, required none");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h11;
    mem[16'h0001] = 8'h33;
    mem[16'h0006] = 8'h42;
    mem[16'h0010] = 8'hC3;
    mem[16'h0020] = 8'h77;
    mem[16'h0021] = 8'h88;
    mem[16'h0200] = 8'hB9;

    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_input_change();
    test_contention();
    test_reset_mid_write();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port system memory (8-bit data, synchronous write, combinational read) between the CPU (port 0) and a program loader/debug master (port 1). Each requester issues a held request with address, write enable and write data; the arbiter selects one winner, drives the memory for exactly one access cycle, then returns a one-cycle acknowledge with registered read data. It sits between the CPU/loader and the `mem` instance, which no longer connects to either master directly.

## Interface
- `ADDR_W`, 16: address width on requester and memory sides.
- `DATA_W`, 8: data width.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: access request; held high until matching `ack`.
- `we0`, `we1` in 1: 1 = write, 0 = read; stable while `req` high.
- `addr0`, `addr1` in ADDR_W: access address; stable while `req` high.
- `wdata0`, `wdata1` in DATA_W: write data; stable while `req` high.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out DATA_W: read data, valid in `ack` cycle, held until next ack to that port.
- `mem_addr` out ADDR_W, `mem_din` out DATA_W, `mem_we` out 1: memory drive.
- `mem_dout` in DATA_W: memory combinational read data.
- `busy` out 1: high in ACC state.

## Operation
- States: IDLE, ACC, DONE. Reset -> IDLE.
- IDLE/DONE: if any `req` pending, pick winner, latch its `addr`/`we`/`wdata`/port id into access registers, go ACC; else go IDLE.
- ACC: `mem_addr`=latched addr, `mem_din`=latched wdata, `mem_we`=latched we; on clock edge capture `mem_dout` into winner's `rdata` (reads only; writes leave `rdata` unchanged); go DONE.
- DONE: pulse winner's `ack`; arbitrate again in same cycle (see above).
- A `req` high during its own `ack` cycle is a new request (back-to-back allowed).
- Outside ACC: `mem_we`=0, `mem_addr`/`mem_din` hold last latched values.
- Only one `ack` ever high per cycle; never an `ack` without a prior grant.
- Address/data are latched; changes on requester inputs after grant do not affect the access.
- Reset values: `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, RR pointer = port 0.
- Reset mid-ACC: state forced IDLE immediately, `mem_we` drops asynchronously, access aborted, no `ack`.

## Timing
- Latency: `req` sampled at edge N (IDLE) -> ACC cycle N+1 -> `ack` in cycle N+2.
- Throughput: one access per 2 cycles under continuous requests (ACC, DONE, ACC, ...).
- Memory write occurs at the rising edge ending ACC; read data registered at the same edge.
- Arbitration decision is combinational from registered state and current `req`; no input-to-output combinational path to `ack`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; pointer flips to the non-winning port after each grant; with both requesting, ports alternate.
- Undefined: fixed priority, port 0 always wins; port 1 granted only when `req0` low at arbitration; pointer logic absent.

## Structure
- `mem_arb_pkg`: state enum (IDLE, ACC, DONE), port-id constants `PORT_CPU`=0, `PORT_LDR`=1, default widths.
- Sub-module `mem_arb_pick`: winner selection from `req0`/`req1` and RR pointer (pointer register inside, compiled per macro); outputs `grant_valid`, `grant_id`.

## Test plan
- Single read: mem[0x0200]=0xB9, `req1` read 0x0200 -> `mem_we` low, `ack1` two cycles after sampling, `rdata1`=0xB9.
- Single write then read: port 0 writes 0x5A to 0x0010, then reads 0x0010 -> second `ack0` with `rdata0`=0x5A.
- Contention: both `req` held high continuously -> with `MEM_ARB_RR_EN` acks alternate 0,1,0,1 every 2 cycles; without it only `ack0` pulses, `ack1` never.
- Back-to-back: port 0 keeps `req0` high through `ack0` with new address 0x0001 -> next ACC begins the cycle after `ack0`, no idle gap.
- Reset mid-write: assert `rst_n`=0 during ACC of a write of 0xFF to 0x0006 -> `mem_we` falls immediately, mem[0x0006] unchanged, no `ack`, all outputs at reset values.
- Input change after grant: alter `addr0` during ACC -> access uses latched address, `rdata0` from original address.
